seven_seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/seven_seg_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for an N-digit common-anode 7-segment display.
// One shared decoder, per-digit blanking gap, frame-aligned double-buffered data.
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned ON_CYC     = 50000,
    parameter int unsigned GAP_CYC    = 500
) (
    input  logic                      iClk,
    input  logic                      iRst_n,
    input  logic                      iEn,
    input  logic                      iLoad,
    input  logic [5*NUM_DIGITS-1:0]   iData,
    input  logic                      iLzb,
    output logic [6:0]                oHex,
    output logic [NUM_DIGITS-1:0]     oDigitSel,
    output logic                      oFrame,
    output logic                      oLoadDone
);

    localparam int unsigned DW   = $clog2(NUM_DIGITS);
    localparam int unsigned BW   = 5 * NUM_DIGITS;
    localparam int unsigned MAXC = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
    localparam logic [6:0]    SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_digit;
    logic [CW-1:0]   r_cnt;
    logic [BW-1:0]   r_shadow;
    logic [BW-1:0]   r_active;
    logic            r_pending;

    logic            w_boundary;
    logic [BW-1:0]   w_src;
    logic [DW-1:0]   w_digit_nxt;

    // Active-low segment pattern {g,f,e,d,c,b,a} for a 5-bit digit code.
    function automatic logic [6:0] f_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'd0:    seg = 7'h40;
            5'd1:    seg = 7'h79;
            5'd2:    seg = 7'h24;
            5'd3:    seg = 7'h30;
            5'd4:    seg = 7'h19;
            5'd5:    seg = 7'h12;
            5'd6:    seg = 7'h02;
            5'd7:    seg = 7'h78;
            5'd8:    seg = 7'h00;
            5'd9:    seg = 7'h10;
            5'd10:   seg = 7'h08;
            5'd11:   seg = 7'h03;
            5'd12:   seg = 7'h46;
            5'd13:   seg = 7'h21;
            5'd14:   seg = 7'h06;
            5'd15:   seg = 7'h0E;
            5'd16:   seg = 7'h3F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Segments for digit d, blanking it if it and every higher digit are zero.
    function automatic logic [6:0] f_seg(input logic [BW-1:0] buf_data,
                                         input logic [DW-1:0] d,
                                         input logic          lzb);
        logic [4:0] code;
        logic       all_zero;
        code     = 5'd31;
        all_zero = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (DW'(k) == d)
                code = buf_data[5*k +: 5];
            if ((DW'(k) >= d) && (buf_data[5*k +: 5] != 5'd0))
                all_zero = 1'b0;
        end
        if (lzb && (d != '0) && all_zero)
            return SEG_BLANK;
        return f_decode(code);
    endfunction

    // Frame boundary: entering ON(0) from IDLE or from the last gap.
    always_comb begin
        w_boundary  = iEn && ((r_state == S_IDLE) ||
                      ((r_state == S_GAP) && (r_cnt == GAP_LAST) && (r_digit == LAST_DIGIT)));
        w_src       = (w_boundary && r_pending) ? r_shadow : r_active;
        w_digit_nxt = r_digit + DW'(1);
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state   <= S_IDLE;
            r_digit   <= '0;
            r_cnt     <= '0;
            r_shadow  <= '1;
            r_active  <= '1;
            r_pending <= 1'b0;
            oHex      <= SEG_BLANK;
            oDigitSel <= '1;
            oFrame    <= 1'b0;
            oLoadDone <= 1'b0;
        end else begin
            oFrame    <= w_boundary;
            oLoadDone <= w_boundary && r_pending;

            // A load on the boundary cycle lands in shadow after the old shadow moves.
            if (w_boundary && r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
            if (iLoad) begin
                r_shadow  <= iData;
                r_pending <= 1'b1;
            end

            if (w_boundary) begin
                r_state   <= S_ON;
                r_digit   <= '0;
                r_cnt     <= '0;
                oDigitSel <= ~NUM_DIGITS'(1);
                oHex      <= f_seg(w_src, '0, iLzb);
            end else if (!iEn) begin
                r_state   <= S_IDLE;
                r_digit   <= '0;
                r_cnt     <= '0;
                oDigitSel <= '1;
                oHex      <= SEG_BLANK;
            end else begin
                case (r_state)
                    S_ON: begin
                        if (r_cnt == ON_LAST) begin
                            r_state   <= S_GAP;
                            r_cnt     <= '0;
                            oDigitSel <= '1;
                            oHex      <= SEG_BLANK;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                            oHex  <= f_seg(r_active, r_digit, iLzb);
                        end
                    end
                    S_GAP: begin
                        if (r_cnt == GAP_LAST) begin
                            r_state   <= S_ON;
                            r_cnt     <= '0;
                            r_digit   <= w_digit_nxt;
                            oDigitSel <= ~(NUM_DIGITS'(1) << w_digit_nxt);
                            oHex      <= f_seg(r_active, w_digit_nxt, iLzb);
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_digit   <= '0;
                        r_cnt     <= '0;
                        oDigitSel <= '1;
                        oHex      <= SEG_BLANK;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed and random steps checked cycle by cycle
// against a time-based model of the scan (slot = position within the frame period).
module tb_seven_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int ON    = 4;
    localparam int GAP   = 1;
    localparam int SLOT  = ON + GAP;
    localparam int FRAME = N * SLOT;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic           load;
    logic [5*N-1:0] data;
    logic           lzb;
    logic [6:0]     hex;
    logic [N-1:0]   sel;
    logic           frame;
    logic           load_done;

    seven_seg_scan_ctrl #(.NUM_DIGITS(N), .ON_CYC(ON), .GAP_CYC(GAP)) dut (
        .iClk      (clk),
        .iRst_n    (rst_n),
        .iEn       (en),
        .iLoad     (load),
        .iData     (data),
        .iLzb      (lzb),
        .oHex      (hex),
        .oDigitSel (sel),
        .oFrame    (frame),
        .oLoadDone (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tbl [17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                                 7'h3F};

    int total = 0;
    int bad   = 0;

    // Reference model state
    int             m_t;
    bit             m_run;
    logic [5*N-1:0] m_sh;
    logic [5*N-1:0] m_ac;
    bit             m_pend;
    logic [6:0]     e_hex;
    logic [N-1:0]   e_sel;
    logic           e_fr;
    logic           e_ld;

    function automatic logic [6:0] model_seg(input logic [5*N-1:0] word, input int d,
                                             input logic z);
        int hi;
        int code;
        hi = -1;
        for (int k = 0; k < N; k++)
            if (word[5*k +: 5] != 5'd0) hi = k;
        code = int'(word[5*d +: 5]);
        if (z && d > 0 && d > hi) return 7'h7F;
        if (code <= 16) return seg_tbl[code];
        return 7'h7F;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    // One clock edge: advance the model with the sampled inputs, then compare.
    task automatic tick();
        int pos;
        int d;
        @(posedge clk);
        e_fr  = 1'b0;
        e_ld  = 1'b0;
        e_hex = 7'h7F;
        e_sel = '1;
        if (!rst_n) begin
            m_run  = 1'b0;
            m_t    = 0;
            m_sh   = '1;
            m_ac   = '1;
            m_pend = 1'b0;
        end else begin
            if (!en) begin
                m_run = 1'b0;
                m_t   = 0;
            end else begin
                if (m_run) m_t++;
                else begin
                    m_run = 1'b1;
                    m_t   = 0;
                end
                pos = m_t % FRAME;
                if (pos == 0) begin
                    e_fr = 1'b1;
                    if (m_pend) begin
                        m_ac   = m_sh;
                        m_pend = 1'b0;
                        e_ld   = 1'b1;
                    end
                end
                d = pos / SLOT;
                if ((pos % SLOT) < ON) begin
                    e_sel = ~(N'(1) << d);
                    e_hex = model_seg(m_ac, d, lzb);
                end
            end
            if (load) begin
                m_sh   = data;
                m_pend = 1'b1;
            end
        end
        #1;
        chk("hex",       8'(hex),       8'(e_hex));
        chk("digit_sel", 8'(sel),       8'(e_sel));
        chk("frame",     8'(frame),     8'(e_fr));
        chk("load_done", 8'(load_done), 8'(e_ld));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Step until the model sits at frame position p (bounded).
    task automatic wait_pos(input int p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 3 * FRAME && !hit; i++) begin
            if (m_run && (m_t % FRAME) == p) hit = 1'b1;
            else tick();
        end
        if (!hit) begin
            total++;
            bad++;
            $error("FAIL wait_pos observed=timeout expected=pos%0d", p);
        end
    endtask

    function automatic logic [5*N-1:0] pack4(input int d3, input int d2, input int d1,
                                             input int d0);
        return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        load  = 1'b0;
        data  = '0;
        lzb   = 1'b0;
        m_t   = 0;
        m_run = 1'b0;
        m_sh  = '1;
        m_ac  = '1;
        m_pend = 1'b0;

        // Reset values
        run(3);
        rst_n = 1'b1;
        run(2);

        // Scan with blank buffers
        en = 1'b1;
        run(45);

        // Load {0,1,2,A}
        load = 1'b1;
        data = pack4(0, 1, 2, 10);
        tick();
        load = 1'b0;
        run(45);

        // Leading-zero suppression on and off
        load = 1'b1;
        data = pack4(0, 0, 5, 0);
        lzb  = 1'b1;
        tick();
        load = 1'b0;
        run(40);
        lzb = 1'b0;
        run(20);

        // Load during ON(2), then again on the boundary cycle
        wait_pos(11);
        load = 1'b1;
        data = pack4(7, 8, 9, 11);
        tick();
        load = 1'b0;
        wait_pos(FRAME - 1);
        load = 1'b1;
        data = pack4(12, 13, 16, 20);
        tick();
        load = 1'b0;
        run(45);

        // Disable during ON(1), then restart
        wait_pos(6);
        en = 1'b0;
        run(4);
        en = 1'b1;
        run(25);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < N; k++)
                data[5*k +: 5] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 30) == 0) lzb = ~lzb;
            en = ($urandom_range(0, 40) != 0);
            tick();
        end
        load = 1'b0;
        en   = 1'b1;
        run(25);

        // Reset during GAP(3) with a pending load
        wait_pos(5);
        load = 1'b1;
        data = pack4(1, 2, 3, 4);
        tick();
        load = 1'b0;
        wait_pos(FRAME - 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run(45);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
